// File: rtl/afe_emulator.sv
// Pulse-oximeter analog front end model: PPG pulse generator, LED/DC-comp light sum,
// PGA and clamped 8-bit ADC, so the controller's calibration loop can close without hardware.
module afe_emulator #(
    parameter int HEART_PERIOD = 1000,
    parameter int RISE_CYCLES  = 200,
    parameter int BASE_RED     = 100,
    parameter int BASE_IR      = 110,
    parameter int AC_RED       = 16,
    parameter int AC_IR        = 24,
    parameter int DARK         = 2,
    parameter int COMP_STEP    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [3:0] LED_DRIVE,
    input  logic [6:0] DC_Comp,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       BEAT
);

    localparam int UP_STEP = 65280 / RISE_CYCLES;
    localparam int DN_STEP = 65280 / (HEART_PERIOD - RISE_CYCLES);
    localparam int PW      = $clog2(HEART_PERIOD);
    localparam logic [PW-1:0] LAST_PHASE = PW'(HEART_PERIOD - 1);
    localparam logic [PW-1:0] RISE_END   = PW'(RISE_CYCLES);

    logic [PW-1:0]      phase_q, phase_d;
    logic [15:0]        acc_q, acc_d;
    logic [16:0]        acc_up;
    logic               beat_q, beat_d;
    logic signed [13:0] x_q, x_d;
    logic [3:0]         pga_q;
    logic [7:0]         adc_q, adc_d;

    logic [7:0] shape;
    int         wave_r, wave_i, light, y;

    // Heartbeat phase and the triangular PPG shape accumulator.
    // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        phase_d = phase_q + PW'(1);
        beat_d  = 1'b0;
        acc_up  = {1'b0, acc_q} + 17'(UP_STEP);
        acc_d   = acc_q;
        if (phase_q == LAST_PHASE) begin
            phase_d = '0;
            beat_d  = 1'b1;
            acc_d   = '0;
        end else if (phase_q < RISE_END) begin
            acc_d = (acc_up > 17'h0FF00) ? 16'hFF00 : acc_up[15:0];
        end else begin
            acc_d = (acc_q >= 16'(DN_STEP)) ? acc_q - 16'(DN_STEP) : 16'h0000;
        end
    end

    // Stage 1: light reaching the photodiode minus the DC compensation offset.
    always_comb begin
        shape  = acc_q[15:8];
        wave_r = (AC_RED * int'(shape)) >> 8;
        wave_i = (AC_IR * int'(shape)) >> 8;
        light  = DARK;
        if (LED_RED) light = light + (((BASE_RED + wave_r) * int'(LED_DRIVE)) >> 3);
        if (LED_IR)  light = light + (((BASE_IR + wave_i) * int'(LED_DRIVE)) >> 3);
        x_d = 14'(light + COMP_STEP * (int'(DC_Comp) - 64));
    end

    // Stage 2: PGA gain pivots around mid-scale, then the ADC clamps to 0..255.
    always_comb begin
        y = 128 + (((int'(x_q) - 128) * (4 + int'(pga_q))) >>> 2);
        if (y < 0)        adc_d = 8'd0;
        else if (y > 255) adc_d = 8'd255;
        else              adc_d = y[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q <= '0;
            acc_q   <= '0;
            beat_q  <= 1'b0;
            x_q     <= '0;
            pga_q   <= '0;
            adc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            x_q     <= x_d;
            pga_q   <= PGA_Gain;
            adc_q   <= adc_d;
        end
    end

    assign ADC  = adc_q;
    assign BEAT = beat_q;

endmodule

// File: tb/tb_afe_emulator.sv
// Scoreboard bench for afe_emulator: a behavioural model predicts each ADC sample
// when inputs are driven; predictions are popped two edges later and compared.
module tb_afe_emulator;

    localparam int HP   = 1000;
    localparam int RISE = 200;
    localparam int UP   = 65280 / RISE;
    localparam int DN   = 65280 / (HP - RISE);

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       LED_RED = 1'b0;
    logic       LED_IR = 1'b0;
    logic [3:0] LED_DRIVE = 4'd8;
    logic [6:0] DC_Comp = 7'd64;
    logic [3:0] PGA_Gain = 4'd0;
    logic [7:0] ADC;
    logic       BEAT;

    int n_cmp = 0;
    int n_err = 0;
    int tb_edges = 0;
    int sb_q[$];

    always #5 CLK = ~CLK;

    afe_emulator dut (
        .CLK      (CLK),
        .RST      (RST),
        .LED_RED  (LED_RED),
        .LED_IR   (LED_IR),
        .LED_DRIVE(LED_DRIVE),
        .DC_Comp  (DC_Comp),
        .PGA_Gain (PGA_Gain),
        .ADC      (ADC),
        .BEAT     (BEAT)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t, edge %0d)", tag, obs, exp, $time, tb_edges);
        end
    endtask

    // Closed-form pulse shape at a given phase.
    function automatic int shape_at(input int p);
        int acc, peak;
        peak = (RISE * UP > 65280) ? 65280 : RISE * UP;
        if (p <= RISE) begin
            acc = p * UP;
            if (acc > 65280) acc = 65280;
        end else begin
            acc = peak - (p - RISE) * DN;
            if (acc < 0) acc = 0;
        end
        return acc >> 8;
    endfunction

    function automatic int model_adc(input int red, input int ir, input int drv,
                                     input int dc, input int gain, input int p);
        int s, light, x, y;
        s = shape_at(p);
        light = 2;
        if (red != 0) light += ((100 + ((16 * s) >> 8)) * drv) >> 3;
        if (ir != 0)  light += ((110 + ((24 * s) >> 8)) * drv) >> 3;
        x = light + 4 * (dc - 64);
        y = 128 + (((x - 128) * (4 + gain)) >>> 2);
        if (y < 0)   return 0;
        if (y > 255) return 255;
        return y;
    endfunction

    // Called at a falling edge; drives inputs, predicts, clocks once, checks, returns at next falling edge.
    task automatic step(input logic red, input logic ir, input logic [3:0] drv,
                        input logic [6:0] dc, input logic [3:0] gain);
        LED_RED   = red;
        LED_IR    = ir;
        LED_DRIVE = drv;
        DC_Comp   = dc;
        PGA_Gain  = gain;
        sb_q.push_back(model_adc(int'(red), int'(ir), int'(drv), int'(dc), int'(gain), tb_edges % HP));
        @(posedge CLK);
        #1;
        tb_edges++;
        check("beat", int'(BEAT), (tb_edges % HP == 0) ? 1 : 0);
        if (sb_q.size() >= 2) check("adc", int'(ADC), sb_q.pop_front());
        else                  check("adc_first", int'(ADC), 0);
        @(negedge CLK);
    endtask

    task automatic release_rst();
        @(negedge CLK);
        RST = 1'b0;
        tb_edges = 0;
        sb_q.delete();
    endtask

    initial begin
        #1 RST = 1'b1;
        #2;
        check("rst_adc", int'(ADC), 0);
        check("rst_beat", int'(BEAT), 0);
        repeat (2) @(posedge CLK);
        release_rst();

        // Idle, red DC, gain, clamps, fast toggling, dual LED and IR-only near phase 0.
        repeat (3) step(1'b0, 1'b0, 4'd8, 7'd64, 4'd0);
        step(1'b1, 1'b0, 4'd8, 7'd64, 4'd0);
        step(1'b1, 1'b0, 4'd8, 7'd71, 4'd15);
        step(1'b1, 1'b0, 4'd8, 7'd127, 4'd0);
        step(1'b1, 1'b0, 4'd8, 7'd0, 4'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd8, (i % 2 == 0) ? 7'd0 : 7'd127, 4'd0);
        step(1'b1, 1'b1, 4'd4, 7'd64, 4'd0);
        step(1'b0, 1'b1, 4'd8, 7'd64, 4'd0);
        step(1'b1, 1'b1, 4'd15, 7'd40, 4'd7);

        // Fresh start so phase 0 lines up, then three full heartbeats with red on.
        RST = 1'b1;
        @(posedge CLK);
        release_rst();
        step(1'b1, 1'b0, 4'd8, 7'd64, 4'd0);
        step(1'b0, 1'b1, 4'd8, 7'd64, 4'd0);
        step(1'b1, 1'b1, 4'd4, 7'd64, 4'd0);
        while (tb_edges < 3 * HP) step(1'b1, 1'b0, 4'd8, 7'd64, 4'd0);

        // Asynchronous reset mid rising slope.
        while (tb_edges % HP != 150) step(1'b1, 1'b0, 4'd8, 7'd64, 4'd0);
        #2 RST = 1'b1;
        #1;
        check("async_rst_adc", int'(ADC), 0);
        check("async_rst_beat", int'(BEAT), 0);
        @(posedge CLK);
        release_rst();
        repeat (HP + 100) step(1'b1, 1'b0, 4'd8, 7'd64, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
